matrix_cmd_sequencer: RTL
=========================

MATRIX_CMD_SEQUENCER -- requirements
Module: matrix_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command queue entries (power of two, 2..16).
REQ-002 SHALL have parameter ENABLE_CYCLES, default 10: clocks CPUEnable is held high per issued command.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit in WAIT (used only with SEQ_TIMEOUT_EN).
REQ-004 SHALL have ports as listed; one clock; reset is asynchronous and active-low.
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- CmdValid  in  1  host command present
- CmdReady  out  1  queue can accept a command
- CmdOp  in  3  operation code (001 Add, 010 Subtract, 011 Transpose, 100 ScalarMultiply, 101 MatrixMultiply, 110 CustomWrite)
- CmdAddr1, CmdAddr2  in  32 each  operand/destination addresses
- OperationOut  out  3  to CPU OperationIn
- Address1Out, Address2Out  out  32 each  to CPU Address1/Address2
- CPUEnable  out  1  to CPU CPUEnable
- CPUDone  in  1  OR of CPU RAMDone/AddDone/SubDone/TranDone/MMDone/SMDone
- ErrorClear  in  1  clears ErrorFlag
- Busy  out  1  FSM not IDLE
- OpDone  out  1  one-cycle completion pulse
- QueueCount  out  clog2(DEPTH)+1  entries queued
- ErrorFlag  out  1  sticky illegal-op flag
- Timeout  out  1  sticky watchdog flag

Function
REQ-005 SHALL push {CmdOp, CmdAddr1, CmdAddr2} when CmdValid&&CmdReady at a rising edge; CmdReady = (QueueCount < DEPTH), combinational from count only.
REQ-006 SHALL complete the handshake for CmdOp 000 or 111 but not enqueue it, and SHALL set ErrorFlag on the next edge.
REQ-007 SHALL clear ErrorFlag when ErrorClear=1; simultaneous illegal push and ErrorClear leaves ErrorFlag=1.
REQ-008 SHALL keep QueueCount unchanged on simultaneous push and pop; pointers SHALL wrap modulo DEPTH.
REQ-009 SHALL implement FSM IDLE, ISSUE, WAIT, DONE.
REQ-010 In IDLE with QueueCount>0, SHALL pop the head, register it onto OperationOut/Address1Out/Address2Out, set CPUEnable=1 and enter ISSUE on the same edge. A push into an empty queue at edge N therefore gives CPUEnable=1 after edge N+1.
REQ-011 SHALL hold CPUEnable=1 for exactly ENABLE_CYCLES clocks in ISSUE, then drive CPUEnable=0 and enter WAIT.
REQ-012 SHALL ignore CPUDone in ISSUE; in WAIT SHALL complete only on a CPUDone rising edge (registered previous sample 0, current 1).
REQ-013 On completion SHALL enter DONE, assert OpDone for one clock, then return to IDLE. Back-to-back commands SHALL therefore have at least one IDLE clock between OpDone and the next CPUEnable.
REQ-014 SHALL hold OperationOut/Address*Out stable from pop until the next pop.
REQ-015 Busy SHALL equal (state != IDLE).

Reset
REQ-016 Reset=0 SHALL immediately force:
- state IDLE, pointers 0, QueueCount 0
- CPUEnable 0, OpDone 0, ErrorFlag 0, Timeout 0
- OperationOut 000, Address1Out 0, Address2Out 0
REQ-017 Reset mid-operation SHALL flush all queued commands; no OpDone SHALL be produced for the aborted command.

Configuration
REQ-018 With SEQ_TIMEOUT_EN defined:
- a counter SHALL run in WAIT
- if it reaches TIMEOUT_CYCLES without a CPUDone rise, SHALL set Timeout (sticky until reset), skip OpDone and return to IDLE
- the queue SHALL be preserved
REQ-019 Without SEQ_TIMEOUT_EN: Timeout SHALL be tied 0, no counter SHALL be instantiated, and WAIT SHALL persist indefinitely.

Verification
REQ-020 Push Add, addr 1/2 into empty queue at edge N -> OperationOut=001, Address1Out=1, Address2Out=2, CPUEnable=1 from edge N+1 for 10 clocks; after CPUDone rise, OpDone pulses once.
REQ-021 Push 5 commands while FSM in WAIT (DEPTH=4) -> CmdReady=0 after the 4th push, QueueCount=4; 5th accepted only after a pop, and all execute in order.
REQ-022 Push CmdOp=111 -> QueueCount unchanged, ErrorFlag=1; ErrorClear pulse -> ErrorFlag=0.
REQ-023 CPUDone held high from the previous command into the next WAIT -> no completion until CPUDone falls and rises again.
REQ-024 Reset=0 during ISSUE with 2 commands queued -> CPUEnable=0 and QueueCount=0 with no clock edge; no OpDone afterwards.
REQ-025 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, CPUDone stuck 0 -> Timeout=1 after 8 WAIT clocks, FSM to IDLE, next queued command issues.

Source files
------------

// File: rtl/matrix_cmd_sequencer.sv
// Purpose: queues host matrix commands and sequences them one at a time onto the CPU enable/done handshake.
// Latency: a command pushed into an idle, empty queue at edge N raises CPUEnable after edge N+1.
// Backpressure: CmdReady drops while DEPTH commands are queued; illegal opcodes handshake but are dropped.
// Optional feature: define SEQ_TIMEOUT_EN to add the WAIT-state watchdog that drives Timeout.
module matrix_cmd_sequencer #(
  parameter int DEPTH          = 4,
  parameter int ENABLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    CmdValid,
  output logic                    CmdReady,
  input  logic [2:0]              CmdOp,
  input  logic [31:0]             CmdAddr1,
  input  logic [31:0]             CmdAddr2,
  output logic [2:0]              OperationOut,
  output logic [31:0]             Address1Out,
  output logic [31:0]             Address2Out,
  output logic                    CPUEnable,
  input  logic                    CPUDone,
  input  logic                    ErrorClear,
  output logic                    Busy,
  output logic                    OpDone,
  output logic [$clog2(DEPTH):0]  QueueCount,
  output logic                    ErrorFlag,
  output logic                    Timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EN_W  = $clog2(ENABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [EN_W-1:0]  EN_ONE  = 1;
  localparam logic [EN_W-1:0]  EN_LAST = EN_W'(ENABLE_CYCLES - 1);

  // Reject configurations the queue and counters are not built for.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("matrix_cmd_sequencer: DEPTH must be a power of two in 2..16");
  end
  if (ENABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("matrix_cmd_sequencer: ENABLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  logic [2:0]       q_op [DEPTH];
  logic [31:0]      q_a1 [DEPTH];
  logic [31:0]      q_a2 [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [EN_W-1:0]  en_cnt;
  logic             done_prev;

  logic cmd_fire;
  logic cmd_illegal;
  logic cmd_push;
  logic cmd_pop;
  logic done_rise;

  assign CmdReady    = (count < DEPTH_C);
  assign cmd_fire    = CmdValid && CmdReady;
  assign cmd_illegal = cmd_fire && ((CmdOp == 3'b000) || (CmdOp == 3'b111));
  assign cmd_push    = cmd_fire && !cmd_illegal;
  assign cmd_pop     = (state == IDLE) && (count != '0);
  assign done_rise   = CPUDone && !done_prev;
  assign QueueCount  = count;
  assign Busy        = (state != IDLE);

  // Queue storage carries no reset: only entries below count are ever read.
  always_ff @(posedge Clock) begin
    if (cmd_push) begin
      q_op[wr_ptr] <= CmdOp;
      q_a1[wr_ptr] <= CmdAddr1;
      q_a2[wr_ptr] <= CmdAddr2;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; push+pop leaves count alone.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (cmd_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (cmd_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({cmd_push, cmd_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky illegal-op flag; a new illegal push beats a simultaneous clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ErrorFlag <= 1'b0;
    end else if (cmd_illegal) begin
      ErrorFlag <= 1'b1;
    end else if (ErrorClear) begin
      ErrorFlag <= 1'b0;
    end
  end

  // Previous CPUDone sample, tracked in every state so a level held over from
  // an earlier command never looks like a fresh completion.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      done_prev <= 1'b0;
    end else begin
      done_prev <= CPUDone;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_ONE  = 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign Timeout = 1'b0;
`endif

  // Command FSM: pop and register the head, hold enable, wait for a done edge, pulse OpDone.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      en_cnt       <= '0;
      CPUEnable    <= 1'b0;
      OpDone       <= 1'b0;
      OperationOut <= 3'b000;
      Address1Out  <= '0;
      Address2Out  <= '0;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt       <= '0;
      Timeout      <= 1'b0;
`endif
    end else begin
      OpDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_pop) begin
            OperationOut <= q_op[rd_ptr];
            Address1Out  <= q_a1[rd_ptr];
            Address2Out  <= q_a2[rd_ptr];
            CPUEnable    <= 1'b1;
            en_cnt       <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (en_cnt == EN_LAST) begin
            CPUEnable <= 1'b0;
            state     <= WAIT;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end else begin
            en_cnt <= en_cnt + EN_ONE;
          end
        end
        WAIT: begin
          if (done_rise) begin
            OpDone <= 1'b1;
            state  <= DONE;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            Timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
